// File: rtl/gpio_video_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : gpio_video_tx
// Purpose  : Raster-timed RGB444 + HSYNC/VSYNC transmitter for the 36-bit
//            GPIO header feeding a DE1 VGA bridge. Pixels come from an
//            upstream valid/ready source through a 4-entry FIFO. They are
//            popped one per active pixel strobe and blanked outside the
//            visible area. Missing pixels are painted magenta and flagged.
// Ports    :
//   clk           in   1   system clock
//   reset_n       in   1   asynchronous active-low reset
//   i_enable      in   1   1 = run raster, 0 = hold idle (flush, counters 0)
//   i_pix_data    in  12   {R[3:0],G[3:0],B[3:0]}
//   i_pix_valid   in   1   i_pix_data valid
//   o_pix_ready   out  1   FIFO accepts (transfer on valid&ready at clk edge)
//   o_frame_start out  1   one-clk pulse when the raster enters (0,0)
//   o_underflow   out  1   sticky starvation flag, cleared at frame start
//   o_hcount      out 10   current pixel column
//   o_vcount      out 10   current line
//   o_gpio_out    out 36   [2]=VS [3]=HS [7:4]=R [11:8]=G [15:12]=B,
//                          each colour nibble MSB on its lowest header bit
//   o_gpio_oe     out 36   output enables, bits [15:2] set
// Revision : 1.0 - initial release
// ============================================================================
module gpio_video_tx #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_enable,
  input  logic [11:0] i_pix_data,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic        o_frame_start,
  output logic        o_underflow,
  output logic [9:0]  o_hcount,
  output logic [9:0]  o_vcount,
  output logic [35:0] o_gpio_out,
  output logic [35:0] o_gpio_oe
);

  // --------------------------------------------------------------------------
  // Raster geometry
  // --------------------------------------------------------------------------
  localparam int          c_H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          c_V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  c_H_LAST    = 10'(c_H_TOTAL - 1);
  localparam logic [9:0]  c_V_LAST    = 10'(c_V_TOTAL - 1);
  localparam logic [9:0]  c_H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  c_V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]  c_HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  c_HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  c_VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  c_VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Divider is at least one bit wide so CLK_DIV=1 still elaborates cleanly;
  // with a single-state divider the strobe is simply asserted every clk.
  localparam int                  c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_ONE  = c_DIV_W'(1);

  localparam logic [2:0]  c_FIFO_DEPTH  = 3'd4;
  localparam logic [11:0] c_STARVE_RGB  = 12'hF0F;
  localparam logic [35:0] c_GPIO_OE     = 36'h0_0000_FFFC;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_DIV_W-1:0] r_div;
  logic [9:0]         r_h;
  logic [9:0]         r_v;
  logic               r_en_d;
  logic               r_frame_start;
  logic               r_underflow;
  logic [11:0]        r_rgb;
  logic               r_hs;
  logic               r_vs;

  logic [11:0]        r_mem [0:3];
  logic [1:0]         r_wptr;
  logic [1:0]         r_rptr;
  logic [2:0]         r_count;

  // --------------------------------------------------------------------------
  // Combinational decode of the current (pre-increment) raster position
  // --------------------------------------------------------------------------
  logic w_strobe;
  logic w_h_last;
  logic w_v_last;
  logic w_wrap;
  logic w_active;
  logic w_hs_on;
  logic w_vs_on;
  logic w_full;
  logic w_empty;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_starve;
  logic w_fs_next;

  assign w_strobe  = i_enable && (r_div == c_DIV_LAST);
  assign w_h_last  = (r_h == c_H_LAST);
  assign w_v_last  = (r_v == c_V_LAST);
  assign w_wrap    = w_strobe && w_h_last && w_v_last;
  assign w_active  = (r_h < c_H_ACT) && (r_v < c_V_ACT);
  assign w_hs_on   = (r_h >= c_HS_START) && (r_h < c_HS_END);
  assign w_vs_on   = (r_v >= c_VS_START) && (r_v < c_VS_END);

  assign w_full    = (r_count == c_FIFO_DEPTH);
  assign w_empty   = (r_count == 3'd0);

  // reset_n is folded in so the source sees "not ready" while reset is held,
  // even though the FIFO itself reports empty during that time.
  assign w_ready   = reset_n && i_enable && !w_full;
  assign w_push    = i_pix_valid && w_ready;

  // Pop decision uses the occupancy before this edge: a word pushed on the
  // same edge is not visible yet, so an empty FIFO starves even if the
  // source is delivering right now.
  assign w_pop     = w_strobe && w_active && !w_empty;
  assign w_starve  = w_strobe && w_active &&  w_empty;

  // First enabled clk after idle, or the wrap back to the origin.
  assign w_fs_next = i_enable && (!r_en_d || w_wrap);

  // --------------------------------------------------------------------------
  // Pixel divider and raster counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else if (!i_enable) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      if (w_strobe) begin
        r_div <= '0;
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? 10'd0 : (r_v + 10'd1);
        end else begin
          r_h <= r_h + 10'd1;
        end
      end else begin
        r_div <= r_div + c_DIV_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame start pulse and sticky underflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_d        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_en_d        <= i_enable;
      r_frame_start <= w_fs_next;
      if (!i_enable) begin
        r_underflow <= 1'b0;
      end else if (w_starve) begin
        // A fresh starvation wins over the frame-start clear.
        r_underflow <= 1'b1;
      end else if (w_fs_next) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel FIFO (4 x 12). Storage has no reset; validity is tracked by
  // r_count, which is cleared on reset and whenever the raster is idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_pix_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (!i_enable) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output register: sync and colour are captured together on the strobe
  // from the same pre-increment position, giving one pixel period latency
  // with HS, VS and RGB always describing the same pixel.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb <= '0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
    end else if (!i_enable) begin
      r_rgb <= '0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
    end else if (w_strobe) begin
      r_hs <= w_hs_on ? HS_POL : ~HS_POL;
      r_vs <= w_vs_on ? VS_POL : ~VS_POL;
      if (!w_active) begin
        r_rgb <= '0;
      end else if (w_empty) begin
        r_rgb <= c_STARVE_RGB;
      end else begin
        r_rgb <= r_mem[r_rptr];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Header mapping. Each colour nibble is bit-reversed onto the header so the
  // component MSB lands on the lowest pin of its group (R3 on bit 4, etc).
  // --------------------------------------------------------------------------
  logic [35:0] w_gpio;

  always_comb begin
    w_gpio    = '0;
    w_gpio[2] = r_vs;
    w_gpio[3] = r_hs;
    for (int i = 0; i < 4; i++) begin
      w_gpio[4 + i]  = r_rgb[11 - i];
      w_gpio[8 + i]  = r_rgb[7 - i];
      w_gpio[12 + i] = r_rgb[3 - i];
    end
  end

  assign o_pix_ready   = w_ready;
  assign o_frame_start = r_frame_start;
  assign o_underflow   = r_underflow;
  assign o_hcount      = r_h;
  assign o_vcount      = r_v;
  assign o_gpio_out    = w_gpio;
  assign o_gpio_oe     = c_GPIO_OE;

endmodule
`default_nettype wire

// File: tb/tb_gpio_video_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gpio_video_tx
// Purpose  : Self-checking bench for gpio_video_tx on a shrunken raster.
//            A pixel-level reference model (pixel index arithmetic plus a
//            queue of accepted source words) predicts every clk's outputs and
//            pushes them into a scoreboard queue; a monitor on the falling
//            edge compares the DUT against the queued expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_video_tx;

  localparam int   HA  = 8;
  localparam int   HF  = 2;
  localparam int   HSY = 3;
  localparam int   HB  = 3;
  localparam int   VA  = 4;
  localparam int   VF  = 1;
  localparam int   VSY = 2;
  localparam int   VB  = 2;
  localparam int   CD  = 2;
  localparam logic HSP = 1'b0;
  localparam logic VSP = 1'b0;
  localparam int   HT  = HA + HF + HSY + HB;
  localparam int   VT  = VA + VF + VSY + VB;
  localparam int   FRAME_CLKS = HT * VT * CD;

  localparam logic [35:0] IDLE_GPIO = 36'h0_0000_000C;
  localparam logic [35:0] OE_GPIO   = 36'h0_0000_FFFC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_start;
  logic        underflow;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [35:0] gpio_out;
  logic [35:0] gpio_oe;

  always #5 clk = ~clk;

  gpio_video_tx #(
    .H_ACTIVE (HA),  .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
    .V_ACTIVE (VA),  .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
    .HS_POL   (HSP), .VS_POL (VSP), .CLK_DIV (CD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_enable      (enable),
    .i_pix_data    (pix_data),
    .i_pix_valid   (pix_valid),
    .o_pix_ready   (pix_ready),
    .o_frame_start (frame_start),
    .o_underflow   (underflow),
    .o_hcount      (hcount),
    .o_vcount      (vcount),
    .o_gpio_out    (gpio_out),
    .o_gpio_oe     (gpio_oe)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [35:0] gpio;
    int          h;
    int          v;
    bit          fs;
    bit          uf;
    int          fsz;
    logic [11:0] rgb;
  } exp_t;

  exp_t        exp_q[$];
  int          rd_idx      = 0;
  int          vectors     = 0;
  int          miscompares = 0;

  // Reference model state (pixel-level view of the raster)
  logic [11:0] src_q[$];   // words accepted from the source, not yet shown
  int          m_k;        // enabled clks since raster (re)start
  int          m_n;        // pixels emitted since raster (re)start
  bit          m_uf;
  logic [11:0] m_rgb;
  bit          m_hs;       // sync currently asserted
  bit          m_vs;

  function automatic logic [35:0] make_gpio(input logic [11:0] rgb,
                                            input bit hs_on, input bit vs_on);
    logic [35:0] g;
    logic [3:0]  r, gr, b;
    g = '0;
    r  = rgb[11:8];
    gr = rgb[7:4];
    b  = rgb[3:0];
    g[2] = vs_on ? VSP : ~VSP;
    g[3] = hs_on ? HSP : ~HSP;
    for (int i = 0; i < 4; i++) begin
      g[4 + i]  = r[3 - i];
      g[8 + i]  = gr[3 - i];
      g[12 + i] = b[3 - i];
    end
    return g;
  endfunction

  // Model: evaluated on every rising edge with the inputs the DUT samples.
  always @(posedge clk) begin
    bit   strobe;
    bit   ready_pre;
    bit   starve;
    bit   fs;
    int   h;
    int   v;
    exp_t e;
    fs = 1'b0;
    if (!reset_n || !enable) begin
      src_q.delete();
      m_k   = 0;
      m_n   = 0;
      m_uf  = 1'b0;
      m_rgb = '0;
      m_hs  = 1'b0;
      m_vs  = 1'b0;
    end else begin
      ready_pre = (src_q.size() < 4);
      strobe    = ((m_k % CD) == CD - 1);
      starve    = 1'b0;
      fs        = (m_k == 0);
      if (strobe) begin
        h = m_n % HT;
        v = (m_n / HT) % VT;
        m_hs = (h >= HA + HF) && (h < HA + HF + HSY);
        m_vs = (v >= VA + VF) && (v < VA + VF + VSY);
        if (h < HA && v < VA) begin
          if (src_q.size() > 0) begin
            m_rgb = src_q.pop_front();
          end else begin
            m_rgb  = 12'hF0F;
            starve = 1'b1;
          end
        end else begin
          m_rgb = '0;
        end
        if ((m_n % (HT * VT)) == HT * VT - 1) fs = 1'b1;
        m_n++;
      end
      if (starve)  m_uf = 1'b1;
      else if (fs) m_uf = 1'b0;
      if (pix_valid && ready_pre) src_q.push_back(pix_data);
      m_k++;
    end
    e.gpio = make_gpio(m_rgb, m_hs, m_vs);
    e.h    = m_n % HT;
    e.v    = (m_n / HT) % VT;
    e.fs   = fs;
    e.uf   = m_uf;
    e.fsz  = src_q.size();
    e.rgb  = m_rgb;
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rd_idx < exp_q.size()) begin
      e = exp_q[rd_idx];
      rd_idx++;
      chk("gpio_oe", gpio_oe, OE_GPIO);
      if (!reset_n) begin
        chk("rst_gpio",  gpio_out,          IDLE_GPIO);
        chk("rst_hcnt",  36'(hcount),       36'd0);
        chk("rst_vcnt",  36'(vcount),       36'd0);
        chk("rst_fs",    36'(frame_start),  36'd0);
        chk("rst_uf",    36'(underflow),    36'd0);
        chk("rst_ready", 36'(pix_ready),    36'd0);
      end else begin
        chk("gpio",      gpio_out,          e.gpio);
        chk("hcount",    36'(hcount),       36'(e.h));
        chk("vcount",    36'(vcount),       36'(e.v));
        chk("frame_st",  36'(frame_start),  36'(e.fs));
        chk("underflow", 36'(underflow),    36'(e.uf));
        chk("pix_ready", 36'(pix_ready),    36'(enable && (e.fsz < 4)));
        if (e.rgb == 12'h8C3) begin
          // Header pins [15:4] for colour 8C3 read as C31 (nibbles reversed).
          chk("rgb_8C3_pins", 36'(gpio_out[15:4]), 36'h0_0000_0C31);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic drive(input bit en, input bit v, input logic [11:0] d);
    @(posedge clk);
    #1;
    enable    = en;
    pix_valid = v;
    pix_data  = d;
  endtask

  task automatic run_random(input int clks, input int pct_valid);
    for (int i = 0; i < clks; i++) begin
      drive(1'b1, ($urandom_range(0, 99) < pct_valid), 12'($urandom));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;

    // Well-fed source across two full frames.
    run_random(2 * FRAME_CLKS + 20, 90);

    // Drop enable mid-frame for 5 clks, then restart with 8C3 as first pixel.
    repeat (5) drive(1'b0, 1'b1, 12'($urandom));
    drive(1'b1, 1'b1, 12'h8C3);
    run_random(60, 100);

    // Source stall of several pixels inside the active area, then recover.
    repeat (12) drive(1'b1, 1'b0, 12'h000);
    run_random(FRAME_CLKS + 40, 100);

    // Sparse source: frequent starvation.
    run_random(FRAME_CLKS, 30);

    // Random enable glitches.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 99) < 70), 12'($urandom));
    end

    // Asynchronous reset in the middle of a cycle, then normal raster.
    run_random(37, 90);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_random(FRAME_CLKS + 10, 90);

    repeat (3) drive(1'b1, 1'b0, 12'h000);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
